// File: rtl/memref_rd_server.sv
// -----------------------------------------------------------------------------
// memref_rd_server
//
// Memory-side responder for a kernel's read-only memref port. It works in
// three phases:
//   1. The word array is filled from a valid/ready load stream.
//   2. A one-cycle start pulse `t` is sent to the kernel.
//   3. The kernel's p0 read requests are served with a fixed one-cycle
//      latency until the kernel raises `done`, which returns the block to
//      loading.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   ld_valid/ld_ready/ld_data
//                   load stream. A word transfers on any rising edge where
//                   ld_valid && ld_ready. ld_ready is high only in LOAD and
//                   never depends on ld_valid. The source may present
//                   ld_data early but must hold it stable until the transfer.
//   t               kernel start pulse, high for exactly one cycle (START)
//   done            kernel finished; honoured only in SERVE
//   p0_addr_data    read address
//   p0_rd_en        read request. There is no backpressure. A request in
//                   SERVE cycle N returns data with p0_rd_valid in cycle N+1.
//   p0_rd_data      read data; holds its last value when no read returns
//   p0_rd_valid     p0_rd_data was updated this cycle
//   loaded          high in START and SERVE
//   err             sticky: read outside SERVE (or out-of-range read when
//                   range checking is enabled); cleared only by rst
//   dbg_state_o     current FSM state, for observation only
//
// Build option:
//   MEMREF_RD_SERVER_OOB_CHECK_EN
//     When defined, a SERVE read with p0_addr_data >= SIZE returns 0 and
//     sets err. When undefined, no range comparator is built, and
//     out-of-range read data is don't-care.
// -----------------------------------------------------------------------------
module memref_rd_server #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 1024,
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ready,
  output logic              t,
  input  logic              done,
  input  logic [ADDR_W-1:0] p0_addr_data,
  input  logic              p0_rd_en,
  output logic [WIDTH-1:0]  p0_rd_data,
  output logic              p0_rd_valid,
  output logic              loaded,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  // Storage. There is no reset on the array, so it can map onto a BRAM.
  logic [WIDTH-1:0] mem [SIZE];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              t_q, t_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic              ld_fire;
  logic              rd_fire;
  logic              rd_bad;
  logic              rd_oob;
  logic [WIDTH-1:0]  rd_word;

  // ld_ready and loaded come straight from the state register. They are
  // gated by rst so both read 0 while reset is held, even in the cycle
  // before the synchronous reset has taken effect.
  assign ld_ready = (state_q == ST_LOAD) && !rst;
  assign loaded   = ((state_q == ST_START) || (state_q == ST_SERVE)) && !rst;

  assign ld_fire  = ld_valid && ld_ready;
  assign rd_fire  = p0_rd_en && (state_q == ST_SERVE);
  // A request in LOAD or START is dropped, but it is flagged.
  assign rd_bad   = p0_rd_en && (state_q != ST_SERVE);

`ifdef MEMREF_RD_SERVER_OOB_CHECK_EN
  assign rd_oob  = rd_fire && (int'(p0_addr_data) >= SIZE);
  assign rd_word = rd_oob ? '0 : mem[p0_addr_data];
`else
  assign rd_oob  = 1'b0;
  assign rd_word = mem[p0_addr_data];
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        // A read issued together with done is still served. The read
        // pipeline below does not look at the next state.
        if (done) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs.
  always_comb begin
    // t is registered. It rises with the state entering START, so it is
    // high for exactly the START cycle.
    t_d        = (state_d == ST_START);
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_word : rd_data_q;
    err_d      = err_q || rd_bad || rd_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      t_q        <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array write port. ld_fire is already qualified by reset through ld_ready.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem[cnt_q] <= ld_data;
    end
  end

  assign t           = t_q;
  assign p0_rd_data  = rd_data_q;
  assign p0_rd_valid = rd_valid_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memref_rd_server.sv
// -----------------------------------------------------------------------------
// tb_memref_rd_server
//
// Directed bench for memref_rd_server.
//   u_dut : SIZE = 1024. Covers load, start pulse timing, serving, done,
//           mid-load reset, and the protocol error flag.
//   u_oob : SIZE = 1000. Covers the out-of-range read.
//
// Each read request pushes its expected data and due cycle into a queue.
// A separate monitor pops and compares entries when the read comes back.
// -----------------------------------------------------------------------------
module tb_memref_rd_server;

  localparam int W  = 32;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int N2 = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic [W-1:0]  ld_data = '0;
  logic          ld_ready;
  logic          t;
  logic          done = 1'b0;
  logic [AW-1:0] p0_addr_data = '0;
  logic          p0_rd_en = 1'b0;
  logic [W-1:0]  p0_rd_data;
  logic          p0_rd_valid;
  logic          loaded;
  logic          err;
  logic [1:0]    dbg_state;

  memref_rd_server #(.WIDTH(W), .SIZE(N), .ADDR_W(AW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .t            (t),
    .done         (done),
    .p0_addr_data (p0_addr_data),
    .p0_rd_en     (p0_rd_en),
    .p0_rd_data   (p0_rd_data),
    .p0_rd_valid  (p0_rd_valid),
    .loaded       (loaded),
    .err          (err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- SIZE = 1000 DUT ----------------
  logic          o_rst = 1'b1;
  logic          o_ld_valid = 1'b0;
  logic [W-1:0]  o_ld_data = '0;
  logic          o_ld_ready;
  logic          o_t;
  logic          o_done = 1'b0;
  logic [AW-1:0] o_addr = '0;
  logic          o_rd_en = 1'b0;
  logic [W-1:0]  o_rd_data;
  logic          o_rd_valid;
  logic          o_loaded;
  logic          o_err;
  logic [1:0]    o_dbg_state;

  memref_rd_server #(.WIDTH(W), .SIZE(N2), .ADDR_W(AW)) u_oob (
    .clk          (clk),
    .rst          (o_rst),
    .ld_valid     (o_ld_valid),
    .ld_data      (o_ld_data),
    .ld_ready     (o_ld_ready),
    .t            (o_t),
    .done         (o_done),
    .p0_addr_data (o_addr),
    .p0_rd_en     (o_rd_en),
    .p0_rd_data   (o_rd_data),
    .p0_rd_valid  (o_rd_valid),
    .loaded       (o_loaded),
    .err          (o_err),
    .dbg_state_o  (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Read-return monitor for u_dut.
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("rd_valid", 32'(p0_rd_valid), 32'd1);
      check("rd_data", p0_rd_data, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else if (p0_rd_valid) begin
      check("unexpected_rd_valid", 32'(p0_rd_valid), 32'd0);
    end
  end

  // Start-pulse monitor for u_dut.
  int t_count = 0;
  int t_last  = -1;
  always @(negedge clk) begin
    if (t) begin
      t_count++;
      t_last = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start just after a rising edge and return just after one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input int mult, output int c0);
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = W'(i * mult);
      step();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  // Issue one SERVE read. The expected data is due on the next cycle.
  task automatic rd(input int a, input logic [W-1:0] e);
    p0_rd_en     = 1'b1;
    p0_addr_data = AW'(a);
    exp_q.push_back(e);
    due_q.push_back(cyc + 1);
    step();
    p0_rd_en = 1'b0;
  endtask

  // Called right after the last load word is accepted.
  task automatic expect_start(input int c0, input int cnt_before);
    @(negedge clk);
    check("t_high", 32'(t), 32'd1);
    check("loaded_in_start", 32'(loaded), 32'd1);
    check("ld_ready_in_start", 32'(ld_ready), 32'd0);
    @(negedge clk);
    check("t_one_cycle", 32'(t), 32'd0);
    check("t_pulse_count", 32'(t_count), 32'(cnt_before + 1));
    check("t_cycle_after_first_accept", 32'(t_last - c0), 32'd1024);
    check("ld_ready_in_serve", 32'(ld_ready), 32'd0);
    step();
  endtask

  task automatic do_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int  c0;
  int  tc;
  bit  seen;

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_t", 32'(t), 32'd0);
    check("rst_rd_data", p0_rd_data, 32'd0);
    check("rst_rd_valid", 32'(p0_rd_valid), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ld_ready_after_rst", 32'(ld_ready), 32'd1);
    check("loaded_in_load", 32'(loaded), 32'd0);
    step();

    // A read in LOAD is dropped and flagged.
    p0_rd_en     = 1'b1;
    p0_addr_data = AW'(5);
    step();
    p0_rd_en = 1'b0;
    @(negedge clk);
    check("err_read_in_load", 32'(err), 32'd1);
    step();

    // First load: data = index * 3.
    tc = t_count;
    load_words(N, 3, c0);
    expect_start(c0, tc);
    check("loaded_in_serve", 32'(loaded), 32'd1);
    check("err_sticky_1", 32'(err), 32'd1);

    // Back-to-back reads.
    rd(0, 32'd0);
    rd(1, 32'd3);
    rd(1023, 32'd3069);
    step();
    @(negedge clk);
    check("idle_rd_valid", 32'(p0_rd_valid), 32'd0);
    check("idle_rd_data_hold", p0_rd_data, 32'd3069);
    step();

    // A load word in SERVE is not accepted and does not touch mem[0].
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD;
    @(negedge clk);
    check("ld_ready_serve_valid", 32'(ld_ready), 32'd0);
    step();
    ld_valid = 1'b0;
    rd(0, 32'd0);

    // done together with a read: the read is served, and the state is LOAD.
    done         = 1'b1;
    p0_rd_en     = 1'b1;
    p0_addr_data = AW'(7);
    exp_q.push_back(32'd21);
    due_q.push_back(cyc + 1);
    step();
    done     = 1'b0;
    p0_rd_en = 1'b0;
    @(negedge clk);
    check("ld_ready_after_done", 32'(ld_ready), 32'd1);
    check("loaded_after_done", 32'(loaded), 32'd0);
    step();

    // Second load overwrites the array: data = index * 5.
    tc = t_count;
    load_words(N, 5, c0);
    expect_start(c0, tc);
    rd(7, 32'd35);
    rd(1023, 32'd5115);
    step();
    @(negedge clk);
    check("err_sticky_2", 32'(err), 32'd1);
    step();
    do_done();

    // Partial load of 500 words, then reset.
    load_words(500, 7, c0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check("midrst_err_cleared", 32'(err), 32'd0);
    step();
    rst = 1'b0;

    // A full load is needed again: data = index * 11.
    tc = t_count;
    load_words(N, 11, c0);
    expect_start(c0, tc);
    rd(0, 32'd0);
    rd(500, 32'd5500);
    rd(1023, 32'd11253);
    step();
    @(negedge clk);
    check("err_clear_after_rst", 32'(err), 32'd0);
    step();
    do_done();

    // SIZE = 1000 instance: out-of-range read.
    step();
    o_rst = 1'b0;
    for (int i = 0; i < N2; i++) begin
      o_ld_valid = 1'b1;
      o_ld_data  = W'(i + 1);
      step();
    end
    o_ld_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (o_t) seen = 1'b1;
    end
    check("oob_t_seen", 32'(seen), 32'd1);
    step();
    o_rd_en = 1'b1;
    o_addr  = AW'(999);
    step();
    o_addr = AW'(1000);
    @(negedge clk);
    check("oob_last_valid", 32'(o_rd_valid), 32'd1);
    check("oob_last_data", o_rd_data, 32'd1000);
    check("oob_err_before", 32'(o_err), 32'd0);
    step();
    o_rd_en = 1'b0;
    @(negedge clk);
    check("oob_valid", 32'(o_rd_valid), 32'd1);
`ifdef MEMREF_RD_SERVER_OOB_CHECK_EN
    check("oob_data_zero", o_rd_data, 32'd0);
    check("oob_err", 32'(o_err), 32'd1);
`else
    check("oob_err_off", 32'(o_err), 32'd0);
`endif
    step();

    // Drain.
    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
